sort_stream_adapter: RTL
========================

Name: sort_stream_adapter

Overview:
- Stream-side driver for the 8-entry selection-sort engine. It feeds the engine and consumes its result.
- Accepts a frame of N bytes over a valid/ready input stream and writes them into the sorter memory through the sorter's addr/wr/datain port. It then pulses start and waits for the sorter's ready.
- Reads the sorted array back through the sorter's addr/dataout port and emits it on a valid/ready output stream, with a last flag on the final element.
- Also measures the sort duration in clock cycles.

Parameters:
W, 8, data width; must match the sorter.
N, 8, elements per frame; must match the sorter memory depth.
AW, 3, sorter address width; N <= 2**AW.
CW, 16, width of the sort-duration counter.

Ports:
clk  input  1  clock
nrst  input  1  asynchronous reset, active-low
in_valid  input  1  input byte valid
in_data  input  W  input byte
in_ready  output  1  adapter accepts in_data this cycle
out_valid  output  1  out_data holds a sorted element
out_data  output  W  sorted element, ascending order
out_last  output  1  high together with out_valid on element N-1
out_ready  input  1  downstream accepts out_data
s_start  output  1  sorter start pulse
s_wr  output  1  sorter write enable (load port)
s_addr  output  AW  sorter load/read address
s_datain  output  W  sorter write data
s_dataout  input  W  sorter read data; valid 1 cycle after s_addr is presented with s_wr=0, s_start=0, s_ready=1
s_ready  input  1  sorter idle/done
busy  output  1  high outside LOAD
sort_cycles  output  CW  cycles spent in WAIT_SORT for the last frame

Behaviour:
- Reset (nrst low, async): state=LOAD, element counter k=0, out_valid=0, out_last=0, out_data=0, s_start=0, sort_cycles=0, busy=0.
- Engine interface (fixed facts):
  - Sorter memory read is synchronous.
  - While s_ready=1 and s_start=0, s_wr=1 writes s_datain to s_addr at the clock edge.
  - While s_ready=1 and s_start=0, s_wr=0 reads s_addr.
  - s_start while s_ready=1 drops s_ready at the same edge.
- State LOAD:
  - in_ready = s_ready.
  - On handshake (in_valid & in_ready): s_wr=1, s_addr=k, s_datain=in_data, all combinational from the handshake. k increments.
  - When the handshake with k==N-1 occurs: k<=0, go to KICK.
  - Otherwise s_wr=0, s_addr=k.
  - Gaps in in_valid are allowed. Only handshaken bytes are written.
- State KICK: one cycle. s_start=1, s_wr=0, sort_cycles<=0, then go to WAIT_SORT.
- State WAIT_SORT:
  - s_start=0.
  - sort_cycles increments each cycle, saturating at 2**CW-1.
  - When s_ready=1: go to RD. s_ready is sampled from this state only, never in the KICK cycle.
- State RD: s_addr=k, s_wr=0, then go to CAP.
- State CAP:
  - s_addr stays k.
  - out_data<=s_dataout, out_valid<=1, out_last<=(k==N-1).
  - Go to OUT.
- State OUT:
  - out_data, out_last and out_valid are held stable until out_ready.
  - On handshake: out_valid<=0, out_last<=0.
  - If k==N-1: k<=0 and go to LOAD. Otherwise k<=k+1 and go to RD.
  - Throughput is 1 element per 3 cycles when out_ready=1.
- s_start is high only in KICK. s_wr is high only on LOAD handshakes.
- in_ready=0 in every state except LOAD.
- busy = (state != LOAD).
- sort_cycles holds its value after WAIT_SORT until the next KICK.
- Ordering is ascending, as produced by the sorter. Duplicates are all emitted. Each frame is exactly N outputs.
- Back-to-back frames: the first byte of the next frame can be accepted in the cycle after the out_last handshake.
- Reset mid-operation (any state) returns to LOAD with a discarded partial frame. The sorter shares nrst, so no resync is needed.
- out_valid never rises without a prior RD/CAP pair. Output elements are never dropped or duplicated.

Test Plan:
- Stream 05,03,07,01,08,02,06,04 continuously, out_ready=1 -> s_start pulses exactly once after byte 8; out 01,02,...,08; out_last only with 08; busy falls the cycle after the 08 handshake.
- Same frame with out_ready held low 5 cycles before each accept -> out_data/out_last stable while stalled; exactly 8 outputs, no repeats.
- in_valid toggling 1,0,0,1,... with frame FF,00,80,7F,01,FE,40,C0 -> sorter memory addr k holds the k-th handshaken byte; output 00,01,40,7F,80,C0,FE,FF.
- All-equal frame AA x8, then an already-sorted 00..07 -> 8×AA, then 00..07; sort_cycles > 0 for both and equals the measured WAIT_SORT length.
- Assert nrst low during WAIT_SORT -> out_valid=0, busy=0, sort_cycles=0 immediately; after release, in_ready=1 and a fresh frame sorts correctly.
- Two frames back-to-back with in_valid held high -> in_ready=0 from KICK through the final out handshake; second frame output correct and independent of the first.

Source files
------------

// File: rtl/sort_stream_adapter_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sort_stream_adapter_if                                                    |
// | Byte streams (in/out) plus the sorter load/read port, grouped for the    |
// | adapter. slave = adapter side, master = environment side.                 |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface sort_stream_adapter_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_ready;
  logic          s_start;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [W-1:0]  s_datain;
  logic [W-1:0]  s_dataout;
  logic          s_ready;

  modport slave (
    input  in_valid, in_data, out_ready, s_dataout, s_ready,
    output in_ready, out_valid, out_data, out_last,
    output s_start, s_wr, s_addr, s_datain
  );

  modport master (
    output in_valid, in_data, out_ready, s_dataout, s_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  s_start, s_wr, s_addr, s_datain
  );
endinterface
`default_nettype wire

// File: rtl/sort_stream_adapter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sort_stream_adapter                                                       |
// | Loads a frame into the selection-sort engine, kicks it, times it, and    |
// | streams the sorted result back out with a last flag.                     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module sort_stream_adapter #(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  sort_stream_adapter_if.slave bus,
  output logic                 busy,
  output logic [CW-1:0]        sort_cycles
);

  localparam logic [2:0] c_LOAD      = 3'd0;
  localparam logic [2:0] c_KICK      = 3'd1;
  localparam logic [2:0] c_WAIT_SORT = 3'd2;
  localparam logic [2:0] c_RD        = 3'd3;
  localparam logic [2:0] c_CAP       = 3'd4;
  localparam logic [2:0] c_OUT       = 3'd5;

  localparam logic [AW-1:0] c_K_LAST  = AW'(N - 1);
  localparam logic [CW-1:0] c_CYC_MAX = {CW{1'b1}};

  logic [2:0]    r_state;
  logic [AW-1:0] r_k;
  logic          r_out_valid;
  logic          r_out_last;
  logic [W-1:0]  r_out_data;
  logic [CW-1:0] r_sort_cycles;

  logic w_in_ready;
  logic w_in_hs;
  logic w_k_last;

  assign w_in_ready = (r_state == c_LOAD) & bus.s_ready;
  assign w_in_hs    = w_in_ready & bus.in_valid;
  assign w_k_last   = (r_k == c_K_LAST);

  // The address always follows k; writes and reads share it.
  assign bus.in_ready  = w_in_ready;
  assign bus.s_wr      = w_in_hs;
  assign bus.s_addr    = r_k;
  assign bus.s_datain  = bus.in_data;
  assign bus.s_start   = (r_state == c_KICK);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign busy          = (r_state != c_LOAD);
  assign sort_cycles   = r_sort_cycles;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= c_LOAD;
      r_k           <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= '0;
      r_sort_cycles <= '0;
    end else begin
      case (r_state)
        c_LOAD: begin
          if (w_in_hs) begin
            if (w_k_last) begin
              r_k     <= '0;
              r_state <= c_KICK;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        c_KICK: begin
          r_sort_cycles <= '0;
          r_state       <= c_WAIT_SORT;
        end
        c_WAIT_SORT: begin
          if (r_sort_cycles != c_CYC_MAX)
            r_sort_cycles <= r_sort_cycles + 1'b1;
          if (bus.s_ready)
            r_state <= c_RD;
        end
        c_RD: begin
          r_state <= c_CAP;
        end
        // Read data is valid one cycle after RD presented the address.
        c_CAP: begin
          r_out_data  <= bus.s_dataout;
          r_out_valid <= 1'b1;
          r_out_last  <= w_k_last;
          r_state     <= c_OUT;
        end
        c_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_k_last) begin
              r_k     <= '0;
              r_state <= c_LOAD;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= c_RD;
            end
          end
        end
        default: begin
          r_state <= c_LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
